// File: rtl/cpu_bus_arb_pkg.sv
// Shared definitions for the CPU-side bus arbiter and the sprite DMA master.
// State encodings and the bus address that triggers a sprite DMA transfer.
package cpu_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_CPU   = 2'b00,
    ARB_HALT  = 2'b01,
    ARB_ALIGN = 2'b10,
    ARB_DMA   = 2'b11
  } arb_state_e;

  // Write to this address starts an OAM DMA in the sprite DMA master.
  localparam logic [15:0] SPR_DMA_PAGE_ADDR = 16'h4014;

  localparam logic [9:0] STALL_CNT_MAX = 10'h3FF;

endpackage

// File: rtl/cpu_bus_arb.sv
// Arbitrates the CPU-side system bus between the 6502 core and the sprite DMA
// master: halts the CPU via RDY, inserts halt/alignment dummy cycles, muxes the bus.
module cpu_bus_arb
  import cpu_bus_arb_pkg::*;
#(
  parameter int P_ALIGN = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_rdy,
  input  logic        i_spr_req,
  output logic        o_spr_gnt,
  input  logic [15:0] i_spr_addr,
  input  logic        i_spr_wn,
  input  logic [7:0]  i_spr_wdata,
  output logic [7:0]  o_spr_rdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic [9:0]  o_stall_cnt
);

  arb_state_e state_q, state_d;
  logic       par_q, par_d;
  logic [9:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ARB_CPU;
      par_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      par_q       <= par_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    par_d   = ~par_q;
    unique case (state_q)
      ARB_CPU: begin
        if (i_spr_req) state_d = ARB_HALT;
      end
      ARB_HALT: begin
        // Writes cannot be halted; the first read is the dummy cycle.
        if (!i_spr_req)    state_d = ARB_CPU;
        else if (i_cpu_wn) state_d = ARB_ALIGN;
      end
      ARB_ALIGN: begin
        // Leave on odd parity so the first DMA cycle lands on even parity.
        if (!i_spr_req)                   state_d = ARB_CPU;
        else if ((P_ALIGN == 0) || par_q) state_d = ARB_DMA;
      end
      ARB_DMA: begin
        if (!i_spr_req) state_d = ARB_CPU;
      end
      default: state_d = ARB_CPU;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ARB_CPU) begin
      if (i_spr_req) stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 10'd1;
    end
  end

  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    unique case (state_q)
      ARB_ALIGN: o_bus_wn = 1'b1;
      ARB_DMA: begin
        o_bus_addr  = i_spr_addr;
        o_bus_wn    = i_spr_req ? i_spr_wn : 1'b1;
        o_bus_wdata = i_spr_wdata;
      end
      default: ;
    endcase
  end

  assign o_cpu_rdy   = (state_q == ARB_CPU);
  assign o_spr_gnt   = (state_q == ARB_DMA) && i_spr_req;
  assign o_cpu_rdata = i_bus_rdata;
  assign o_spr_rdata = i_bus_rdata;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Bench for cpu_bus_arb: one aligned and one unaligned instance, each checked
// every cycle against an ownership model plus literal DMA timing expectations.
module tb_cpu_bus_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr  [2];
  logic        cpu_wn    [2];
  logic [7:0]  cpu_wdata [2];
  logic        spr_req   [2];
  logic [15:0] spr_addr  [2];
  logic        spr_wn    [2];
  logic [7:0]  spr_wdata [2];
  logic [7:0]  cpu_rdata [2];
  logic        cpu_rdy   [2];
  logic        spr_gnt   [2];
  logic [7:0]  spr_rdata [2];
  logic [15:0] bus_addr  [2];
  logic        bus_wn    [2];
  logic [7:0]  bus_wdata [2];
  logic [7:0]  bus_rdata [2];
  logic [9:0]  stall_cnt [2];

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  function automatic logic [7:0] decode_rd(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Instance 0 aligns the first DMA cycle to even parity, instance 1 does not.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign bus_rdata[gi] = decode_rd(bus_addr[gi]);
      cpu_bus_arb #(.P_ALIGN(gi == 0 ? 1 : 0)) u_dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_cpu_addr  (cpu_addr[gi]),
        .i_cpu_wn    (cpu_wn[gi]),
        .i_cpu_wdata (cpu_wdata[gi]),
        .o_cpu_rdata (cpu_rdata[gi]),
        .o_cpu_rdy   (cpu_rdy[gi]),
        .i_spr_req   (spr_req[gi]),
        .o_spr_gnt   (spr_gnt[gi]),
        .i_spr_addr  (spr_addr[gi]),
        .i_spr_wn    (spr_wn[gi]),
        .i_spr_wdata (spr_wdata[gi]),
        .o_spr_rdata (spr_rdata[gi]),
        .o_bus_addr  (bus_addr[gi]),
        .o_bus_wn    (bus_wn[gi]),
        .o_bus_wdata (bus_wdata[gi]),
        .i_bus_rdata (bus_rdata[gi]),
        .o_stall_cnt (stall_cnt[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h at t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the bus, how many alignment cycles remain.
  bit m_par;
  bit m_cpu_owns  [2];
  bit m_wait_read [2];
  bit m_dma_owns  [2];
  int m_align_left[2];
  int m_stall     [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_par <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_cpu_owns[k]   <= 1'b1;
        m_wait_read[k]  <= 1'b0;
        m_dma_owns[k]   <= 1'b0;
        m_align_left[k] <= 0;
        m_stall[k]      <= 0;
      end
    end else begin
      m_par <= !m_par;
      for (int k = 0; k < 2; k++) begin
        if (m_cpu_owns[k]) begin
          if (spr_req[k]) begin
            m_cpu_owns[k]  <= 1'b0;
            m_wait_read[k] <= 1'b1;
            m_stall[k]     <= 0;
          end
        end else begin
          m_stall[k] <= (m_stall[k] >= 1023) ? 1023 : m_stall[k] + 1;
          if (!spr_req[k]) begin
            m_cpu_owns[k]   <= 1'b1;
            m_wait_read[k]  <= 1'b0;
            m_dma_owns[k]   <= 1'b0;
            m_align_left[k] <= 0;
          end else if (m_wait_read[k]) begin
            if (cpu_wn[k]) begin
              m_wait_read[k]  <= 1'b0;
              // first alignment cycle has parity !m_par; even parity costs an extra one
              m_align_left[k] <= (k == 0 && m_par) ? 2 : 1;
            end
          end else if (m_align_left[k] > 0) begin
            m_align_left[k] <= m_align_left[k] - 1;
            if (m_align_left[k] == 1) m_dma_owns[k] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] e_addr;
        logic        e_wn;
        logic [7:0]  e_wdata;
        e_addr  = cpu_addr[k];
        e_wn    = cpu_wn[k];
        e_wdata = cpu_wdata[k];
        if (m_dma_owns[k]) begin
          e_addr  = spr_addr[k];
          e_wn    = spr_req[k] ? spr_wn[k] : 1'b1;
          e_wdata = spr_wdata[k];
        end else if (m_align_left[k] > 0) begin
          e_wn = 1'b1;
        end
        chk("rdy", k, cpu_rdy[k], m_cpu_owns[k]);
        chk("gnt", k, spr_gnt[k], m_dma_owns[k] && spr_req[k]);
        chk("bus_addr", k, bus_addr[k], e_addr);
        chk("bus_wn", k, bus_wn[k], e_wn);
        chk("bus_wdata", k, bus_wdata[k], e_wdata);
        chk("cpu_rdata", k, cpu_rdata[k], decode_rd(e_addr));
        chk("spr_rdata", k, spr_rdata[k], decode_rd(e_addr));
        chk("stall_cnt", k, stall_cnt[k], m_stall[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic idle(input int k);
    cpu_addr[k] = 16'hC000; cpu_wn[k] = 1'b1; cpu_wdata[k] = 8'h00;
    spr_req[k] = 1'b0; spr_addr[k] = 16'h0000; spr_wn[k] = 1'b1; spr_wdata[k] = 8'h00;
  endtask

  task automatic wait_par(input int p);
    while ((cyc_cnt % 2) != p) cyc();
  endtask

  // Core writes the stack for the first n_wr cycles after req, then reads.
  task automatic set_cpu(input int k, input int rel, input int n_wr);
    if (rel < n_wr) begin
      cpu_addr[k] = 16'h01FD - 16'(rel); cpu_wn[k] = 1'b0; cpu_wdata[k] = 8'hE0 + 8'(rel);
    end else begin
      cpu_addr[k] = 16'hC000 + 16'(rel); cpu_wn[k] = 1'b1; cpu_wdata[k] = 8'h00;
    end
  endtask

  task automatic set_acc(input int k, input int i);
    if (i % 2 == 0) begin
      spr_addr[k] = 16'h0200 + 16'(i / 2); spr_wn[k] = 1'b1; spr_wdata[k] = 8'h00;
    end else begin
      spr_addr[k] = 16'h2004; spr_wn[k] = 1'b0; spr_wdata[k] = 8'(i / 2) ^ 8'h3C;
    end
  endtask

  task automatic do_dma(input int k, input int n, input int want_par, input int n_wr,
                        output int lat, output int stall);
    int t0;
    int w;
    bit ok;
    if (want_par >= 0) wait_par(want_par);
    t0 = cyc_cnt;
    lat = -1;
    ok = 1'b1;
    spr_req[k] = 1'b1;
    set_cpu(k, 0, n_wr);
    for (int i = 0; i < n; i++) begin
      set_acc(k, i);
      #1;
      w = 0;
      while (!spr_gnt[k] && w < 64) begin
        cyc();
        set_cpu(k, cyc_cnt - t0, n_wr);
        #1;
        w++;
      end
      if (!spr_gnt[k]) begin
        checks++;
        failures++;
        $display("FAIL gnt_timeout[%0d] got=0 want=1 at access %0d", k, i);
        ok = 1'b0;
        break;
      end
      if (lat < 0) lat = cyc_cnt - t0;
      if (i == 0) begin
        chk("dma_rd_addr", k, bus_addr[k], 16'h0200);
        chk("dma_rd_wn", k, bus_wn[k], 1'b1);
        chk("dma_rd_data", k, spr_rdata[k], 8'hA7);
      end else if (i == 1) begin
        chk("dma_wr_addr", k, bus_addr[k], 16'h2004);
        chk("dma_wr_wn", k, bus_wn[k], 1'b0);
        chk("dma_wr_data", k, bus_wdata[k], 8'h3C);
      end
      cyc();
      set_cpu(k, cyc_cnt - t0, n_wr);
    end
    spr_req[k] = 1'b0;
    cyc();
    set_cpu(k, cyc_cnt - t0, 0);
    stall = ok ? int'(stall_cnt[k]) : -1;
    chk("rdy_after", k, cpu_rdy[k], 1'b1);
  endtask

  initial begin
    int lat, st, w;
    idle(0);
    idle(1);
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdy", k, cpu_rdy[k], 1'b1);
      chk("rst_gnt", k, spr_gnt[k], 1'b0);
      chk("rst_stall", k, stall_cnt[k], 10'd0);
      chk("rst_bus_addr", k, bus_addr[k], 16'hC000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc_cnt = 0;
    repeat (3) cyc();

    do_dma(0, 512, 0, 0, lat, st);
    chk("lat_a_par0", 0, lat, 4); chk("stall_a_par0", 0, st, 516);
    do_dma(1, 512, 0, 0, lat, st);
    chk("lat_b_par0", 1, lat, 3); chk("stall_b_par0", 1, st, 515);
    do_dma(0, 512, 1, 0, lat, st);
    chk("lat_a_par1", 0, lat, 3); chk("stall_a_par1", 0, st, 515);
    do_dma(1, 512, 1, 0, lat, st);
    chk("lat_b_par1", 1, lat, 3); chk("stall_b_par1", 1, st, 515);
    repeat (2) cyc();

    do_dma(0, 4, 0, 3, lat, st);
    chk("lat_a_wr", 0, lat, 6); chk("stall_a_wr", 0, st, 10);
    do_dma(1, 4, 0, 3, lat, st);
    chk("lat_b_wr", 1, lat, 5); chk("stall_b_wr", 1, st, 9);

    // Abort while aligning; the core strobe is driven low to expose the forced read.
    wait_par(0);
    spr_req[0] = 1'b1; set_acc(0, 0);
    cyc();
    cyc();
    cpu_wn[0] = 1'b0;
    #1 chk("abort_rdy_low", 0, cpu_rdy[0], 1'b0);
    chk("abort_bus_wn", 0, bus_wn[0], 1'b1);
    spr_req[0] = 1'b0;
    #1 chk("abort_gnt", 0, spr_gnt[0], 1'b0);
    cyc();
    chk("abort_rdy_back", 0, cpu_rdy[0], 1'b1);
    chk("abort_stall", 0, stall_cnt[0], 10'd2);
    cpu_wn[0] = 1'b1;
    repeat (2) cyc();

    // Back-to-back transfers: the core sees exactly one RDY cycle between them.
    do_dma(0, 4, 0, 0, lat, st);
    chk("b2b_first_stall", 0, st, 8);
    do_dma(0, 4, -1, 0, lat, st);
    chk("b2b_lat", 0, lat, 3); chk("b2b_stall", 0, st, 7);

    do_dma(0, 1100, 0, 0, lat, st);
    chk("sat_stall", 0, st, 1023);

    // Reset in the middle of a DMA transfer.
    cpu_addr[0] = 16'hBEEF; cpu_wn[0] = 1'b1;
    spr_req[0] = 1'b1; set_acc(0, 0);
    #1;
    w = 0;
    while (!spr_gnt[0] && w < 16) begin cyc(); #1; w++; end
    chk("rst_pre_gnt", 0, spr_gnt[0], 1'b1);
    rst_n = 1'b0;
    spr_req[0] = 1'b0;
    #1;
    chk("mid_rst_rdy", 0, cpu_rdy[0], 1'b1);
    chk("mid_rst_gnt", 0, spr_gnt[0], 1'b0);
    chk("mid_rst_stall", 0, stall_cnt[0], 10'd0);
    chk("mid_rst_addr", 0, bus_addr[0], 16'hBEEF);
    chk("mid_rst_wn", 0, bus_wn[0], 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc_cnt = 0;
    repeat (2) cyc();
    chk("post_rst_rdy", 0, cpu_rdy[0], 1'b1);

    do_dma(1, 2, 0, 0, lat, st);
    chk("post_rst_lat_b", 1, lat, 3); chk("post_rst_stall_b", 1, st, 5);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_bus_arb.md
Name: cpu_bus_arb

Overview:
- Owns the CPU-side 16-bit system bus and arbitrates it between the 6502 core and the sprite DMA master (OAM DMA, the $4014-triggered engine).
- Halts the CPU through RDY and inserts the halt/alignment dummy cycles.
- Muxes address, write strobe and write data onto the shared bus. Returns read data to whichever master owns the bus.
- Sits between the CPU core / sprite DMA master and the address decoder that feeds RAM, PPU and APU registers.

Parameters:
P_ALIGN, 1, 1 = first DMA cycle is forced onto even bus-cycle parity (NES get/put alignment); 0 = no alignment cycle padding.

Ports:
i_clk  in  1  system clock, one bus cycle per clock
i_rstn  in  1  asynchronous active-low reset
i_cpu_addr  in  16  CPU bus address
i_cpu_wn  in  1  CPU write strobe, active low (1 = read)
i_cpu_wdata  in  8  CPU write data
o_cpu_rdata  out  8  read data to CPU
o_cpu_rdy  out  1  CPU RDY; 0 = halt the CPU on its next read cycle
i_spr_req  in  1  DMA bus request, held for the whole transfer
o_spr_gnt  out  1  DMA access completes this cycle
i_spr_addr  in  16  DMA address
i_spr_wn  in  1  DMA write strobe, active low
i_spr_wdata  in  8  DMA write data
o_spr_rdata  out  8  read data to DMA, valid in the same cycle as o_spr_gnt
o_bus_addr  out  16  shared bus address
o_bus_wn  out  1  shared bus write strobe, active low
o_bus_wdata  out  8  shared bus write data
i_bus_rdata  in  8  shared bus read data, combinational from the decoder
o_stall_cnt  out  10  CPU-stalled cycles in the current/last DMA, saturating

Behaviour:
- Reset (async, i_rstn=0): state ARB_CPU, o_cpu_rdy=1, o_spr_gnt=0, parity r_par=0, o_stall_cnt=0. The bus mux selects the CPU.
- r_par toggles every clock after reset.
- States:
  - ARB_CPU: the bus carries CPU address, wn and wdata.
  - ARB_HALT: the bus carries the CPU.
  - ARB_ALIGN: the bus carries the CPU address with o_bus_wn forced to 1 (dummy read).
  - ARB_DMA: the bus carries the DMA.
- o_cpu_rdy = (state==ARB_CPU), registered via the state register.
- ARB_CPU -> ARB_HALT when i_spr_req=1. On that transition o_stall_cnt clears to 0.
- ARB_HALT:
  - The 6502 ignores RDY on write cycles, so while i_cpu_wn=0 it stays in HALT and the CPU write goes to the bus unchanged.
  - On the first cycle with i_cpu_wn=1, that read is a dummy (the CPU repeats it later) and the next state is ARB_ALIGN.
- ARB_ALIGN:
  - Exit to ARB_DMA when P_ALIGN==0 or r_par==1, so the first DMA cycle has r_par=0. Otherwise stay one more cycle.
  - ALIGN therefore lasts 1 or 2 cycles.
- ARB_DMA:
  - o_spr_gnt = i_spr_req, combinationally. The DMA holds each access until gnt.
  - When i_spr_req=0, o_spr_gnt=0 and the bus drives the DMA lines with o_bus_wn forced to 1. Next state is ARB_CPU.
- Abort: i_spr_req falling in ARB_HALT or ARB_ALIGN -> ARB_CPU next cycle. No gnt is ever issued.
- o_cpu_rdata = o_spr_rdata = i_bus_rdata at all times. Consumers qualify by ownership.
- o_stall_cnt increments every cycle the state is not ARB_CPU and saturates at 10'h3FF. It holds its value in ARB_CPU until the next request.
- A request re-raised in the cycle after returning to ARB_CPU is legal. The CPU then gets exactly one RDY=1 cycle.
- Reset mid-DMA: immediate return to ARB_CPU and RDY=1. The DMA master is reset by the same i_rstn.
- Default/illegal state -> ARB_CPU.

Decomposition:
- Shared package holds:
  - state encodings ARB_CPU=2'b00, ARB_HALT=2'b01, ARB_ALIGN=2'b10, ARB_DMA=2'b11
  - constant for the $4014 DMA page register address, shared with the DMA master.
- No sub-module. The bus mux is inline combinational logic driven by the state.

Test Plan:
- CPU reading continuously, req rises at r_par=0, DMA does 512 granted accesses (256 read/write pairs) then drops req -> HALT 1, ALIGN 2, DMA 513, o_stall_cnt=516, RDY=1 afterwards.
- Same stimulus with req rising at r_par=1 -> ALIGN 1 cycle, o_stall_cnt=515. With P_ALIGN=0 both cases give 515.
- CPU issues 3 consecutive writes ($0100-$01FF stack, BRK-like) when req rises -> all 3 writes appear on o_bus_* with wn=0, then 1 dummy read. First gnt comes 5-6 cycles after req.
- DMA read $0200 then write $2004 with gnt: o_bus_addr=16'h0200 wn=1, o_spr_rdata equals i_bus_rdata in the same cycle; next cycle o_bus_addr=16'h2004 wn=0, wdata passed through.
- req drops during ARB_ALIGN -> no o_spr_gnt pulse, RDY=1 on the next cycle.
- i_rstn pulsed low in mid-ARB_DMA -> o_cpu_rdy=1, o_spr_gnt=0, o_stall_cnt=0 asynchronously, and the bus selects the CPU.
